// File: rtl/sp_noise_removal_cfg.sv
// -----------------------------------------------------------------------------
// sp_noise_removal_cfg
//   Salt-and-pepper noise remover for the RAW denoise chain. A BWIDTH x BWIDTH
//   window is built from vertical columns delivered by the upstream line
//   buffer. The centre pixel is compared with the min/max of an 8-pixel
//   neighbourhood widened by a run-time threshold. Outliers are replaced by
//   the mean of the 4 orthogonal neighbours.
//
//   Ports
//     clk, rst_n    clock, asynchronous active-low reset
//     en_i          column valid
//     data_i        pixel column, top row in the MSB slice
//     sof_i         start-of-frame pulse
//     mode_i        0 = mono 3x3 ring, 1 = Bayer same-colour ring (BWIDTH = 5)
//     bypass_i      1 = pass the centre pixel through unmodified
//     sigma_wr_i    threshold write strobe, sigma_i = threshold write data
//     data_o        corrected centre pixel; en_o = valid; flag_o = replaced
//     noise_cnt_o   replaced-pixel count of the previous frame
//
//   Latency: window register -> S1 (neighbour stats) -> S2 (decision).
//   en_o rises two clocks after the en_i beat that completes a window.
// -----------------------------------------------------------------------------
module sp_noise_removal_cfg #(
  parameter int DATADEPTH = 12,
  parameter int BWIDTH    = 5,
  parameter int SIGMA     = 160,
  parameter int CNTW      = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic [DATADEPTH*BWIDTH-1:0]   data_i,
  input  logic                          sof_i,
  input  logic                          mode_i,
  input  logic                          bypass_i,
  input  logic                          sigma_wr_i,
  input  logic [DATADEPTH-1:0]          sigma_i,
  output logic [DATADEPTH-1:0]          data_o,
  output logic                          en_o,
  output logic                          flag_o,
  output logic [CNTW-1:0]               noise_cnt_o
);

  localparam int C  = BWIDTH / 2;
  localparam int D2 = (BWIDTH == 5) ? 2 : 1;   // Bayer same-colour distance
  localparam int FW = $clog2(BWIDTH + 1);
  localparam int SW = DATADEPTH + 2;

  typedef logic [DATADEPTH-1:0] pix_t;
  typedef logic [DATADEPTH:0]   ext_t;

  // Window storage, indexed [column][row]; column BWIDTH-1 is the newest.
  pix_t           win [BWIDTH][BWIDTH];
  logic [FW-1:0]  fill_q;
  logic           win_vld_q;
  logic           win_mode_q;
  logic           win_byp_q;
  pix_t           sigma_q;

  // ---------------------------------------------------------------------------
  // Column shift register
  // ---------------------------------------------------------------------------
  // NOTE: the window is a small register array, not a RAM, so it can take the
  // async reset; a cleared window keeps the first-frame arithmetic defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < BWIDTH; j++)
        for (int r = 0; r < BWIDTH; r++)
          win[j][r] <= '0;
    end else if (en_i) begin
      for (int j = 0; j < BWIDTH - 1; j++)
        for (int r = 0; r < BWIDTH; r++)
          win[j][r] <= win[j+1][r];
      for (int r = 0; r < BWIDTH; r++)
        win[BWIDTH-1][r] <= data_i[(BWIDTH-1-r)*DATADEPTH +: DATADEPTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Fill counter and window-valid; mode/bypass travel with the completing beat
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here so every register samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= '0;
      win_vld_q  <= 1'b0;
      win_mode_q <= 1'b0;
      win_byp_q  <= 1'b0;
    end else begin
      // The beat that reaches BWIDTH, and every later beat, completes a window.
      win_vld_q <= en_i && !sof_i && (fill_q >= FW'(BWIDTH - 1));
      if (en_i) begin
        win_mode_q <= mode_i;
        win_byp_q  <= bypass_i;
      end
      if (sof_i)
        fill_q <= en_i ? FW'(1) : '0;
      else if (en_i && fill_q != FW'(BWIDTH))
        fill_q <= fill_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sigma_q <= pix_t'(SIGMA);
    else if (sigma_wr_i) sigma_q <= sigma_i;
  end

  // ---------------------------------------------------------------------------
  // Neighbourhood: 8 positions of the 3x3 grid around the centre, stretched to
  // distance 2 in Bayer mode. Entries 1,3,4,6 are the orthogonal neighbours.
  // ---------------------------------------------------------------------------
  logic use_bayer;
  pix_t nb [8];
  pix_t nb_min, nb_max;
  logic [SW-1:0] nb_sum;

  assign use_bayer = (BWIDTH == 5) ? win_mode_q : 1'b0;

  for (genvar k = 0; k < 8; k++) begin : g_ring
    localparam int IDX = (k < 4) ? k : k + 1;   // skip the centre of 0..8
    localparam int DR  = IDX / 3 - 1;
    localparam int DC  = IDX % 3 - 1;
    assign nb[k] = use_bayer ? win[C + DC*D2][C + DR*D2] : win[C + DC][C + DR];
  end

  // NOTE: both outputs get a default before the loop so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    nb_min = '1;
    nb_max = '0;
    for (int k = 0; k < 8; k++) begin
      if (nb[k] < nb_min) nb_min = nb[k];
      if (nb[k] > nb_max) nb_max = nb[k];
    end
  end

  assign nb_sum = SW'(nb[1]) + SW'(nb[3]) + SW'(nb[4]) + SW'(nb[6]);

  // ---------------------------------------------------------------------------
  // S1: neighbour statistics, centre, threshold snapshot
  // ---------------------------------------------------------------------------
  pix_t          s1_min, s1_max, s1_ctr, s1_sig;
  logic [SW-1:0] s1_sum;
  logic          s1_byp, s1_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_min <= '0;
      s1_max <= '0;
      s1_ctr <= '0;
      s1_sig <= '0;
      s1_sum <= '0;
      s1_byp <= 1'b0;
      s1_vld <= 1'b0;
    end else begin
      s1_min <= nb_min;
      s1_max <= nb_max;
      s1_ctr <= win[C][C];
      s1_sig <= sigma_q;
      s1_sum <= nb_sum;
      s1_byp <= win_byp_q;
      s1_vld <= win_vld_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: decision. One extra bit keeps max+sigma and centre+sigma from wrapping.
  // ---------------------------------------------------------------------------
  logic noisy, replace;
  ext_t hi_lim, ctr_up;

  assign hi_lim  = ext_t'(s1_max) + ext_t'(s1_sig);
  assign ctr_up  = ext_t'(s1_ctr) + ext_t'(s1_sig);
  assign noisy   = (ext_t'(s1_ctr) > hi_lim) || (ctr_up < ext_t'(s1_min));
  assign replace = noisy && !s1_byp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o <= '0;
      en_o   <= 1'b0;
      flag_o <= 1'b0;
    end else begin
      en_o   <= s1_vld;
      flag_o <= s1_vld && replace;
      if (s1_vld)
        data_o <= replace ? s1_sum[SW-1:2] : s1_ctr;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame noise counter. A flagged pixel leaving S2 in the sof_i cycle
  // belongs to the new frame.
  // ---------------------------------------------------------------------------
  logic [CNTW-1:0] run_q;
  logic            hit;

  assign hit = en_o && flag_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= '0;
      noise_cnt_o <= '0;
    end else if (sof_i) begin
      noise_cnt_o <= run_q;
      run_q       <= hit ? CNTW'(1) : '0;
    end else if (hit && run_q != '1) begin
      run_q <= run_q + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_sp_noise_removal_cfg.sv
// -----------------------------------------------------------------------------
// tb_sp_noise_removal_cfg
//   Self-checking bench for sp_noise_removal_cfg (DATADEPTH=12, BWIDTH=5).
//   A cycle-stamped reference model predicts every output beat from the
//   received columns; table vectors and hand sequences add fixed expectations.
// -----------------------------------------------------------------------------
module tb_sp_noise_removal_cfg;

  localparam int D    = 12;
  localparam int B    = 5;
  localparam int CW   = 20;
  localparam int SIG0 = 160;
  localparam int C    = B / 2;

  typedef logic [D*B-1:0] col_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_i = 1'b0;
  col_t          data_i = '0;
  logic          sof_i = 1'b0;
  logic          mode_i = 1'b0;
  logic          bypass_i = 1'b0;
  logic          sigma_wr_i = 1'b0;
  logic [D-1:0]  sigma_i = '0;
  logic [D-1:0]  data_o;
  logic          en_o;
  logic          flag_o;
  logic [CW-1:0] noise_cnt_o;

  sp_noise_removal_cfg #(.DATADEPTH(D), .BWIDTH(B), .SIGMA(SIG0), .CNTW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .data_i     (data_i),
    .sof_i      (sof_i),
    .mode_i     (mode_i),
    .bypass_i   (bypass_i),
    .sigma_wr_i (sigma_wr_i),
    .sigma_i    (sigma_i),
    .data_o     (data_o),
    .en_o       (en_o),
    .flag_o     (flag_o),
    .noise_cnt_o(noise_cnt_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct { int data; bit flag; } out_t;

  col_t hist[$];          // most recent columns, oldest first
  int   m_fill  = 0;
  int   m_sigma = SIG0;
  int   m_run   = 0;
  int   m_cnt   = 0;
  out_t exp_at[int];      // expected output keyed by the edge it appears at
  int   edge_cnt = 0;
  bit   mon_on   = 1'b0;

  function automatic int pix(input int r, input int c);
    col_t col;
    col = hist[hist.size() - B + c];
    return int'(col[(B-1-r)*D +: D]);
  endfunction

  function automatic out_t ref_window(input bit mode, input bit byp, input int sig);
    out_t o;
    int d, ctr, mn, mx, rep, v;
    bit noisy;
    d   = mode ? 2 : 1;
    ctr = pix(C, C);
    mn  = 1 << 30;
    mx  = -1;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0) begin
          v  = pix(C + dr*d, C + dc*d);
          mn = (v < mn) ? v : mn;
          mx = (v > mx) ? v : mx;
        end
    rep   = (pix(C-d, C) + pix(C+d, C) + pix(C, C-d) + pix(C, C+d)) / 4;
    noisy = (ctr > mx + sig) || (ctr + sig < mn);
    o.flag = noisy && !byp;
    o.data = o.flag ? rep : ctr;
    return o;
  endfunction

  // Advance one clock: the model consumes the inputs the DUT sees at this edge.
  task automatic tick();
    bit f;
    @(posedge clk);
    edge_cnt++;
    f = exp_at.exists(edge_cnt - 1) && exp_at[edge_cnt - 1].flag;
    if (sof_i) begin
      m_cnt = m_run;
      m_run = f ? 1 : 0;
    end else if (f && m_run < (1 << CW) - 1) begin
      m_run++;
    end
    if (sigma_wr_i) m_sigma = int'(sigma_i);
    if (sof_i) m_fill = 0;
    if (en_i) begin
      hist.push_back(data_i);
      if (hist.size() > B) void'(hist.pop_front());
      if (m_fill < B) m_fill++;
      if (m_fill == B) exp_at[edge_cnt + 2] = ref_window(mode_i, bypass_i, m_sigma);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_at.exists(edge_cnt)) begin
        check("en_o beat", en_o, 1);
        check("data_o", data_o, exp_at[edge_cnt].data);
        check("flag_o", flag_o, exp_at[edge_cnt].flag);
      end else begin
        check("en_o idle", en_o, 0);
      end
      check("noise_cnt_o", noise_cnt_o, m_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic beat(input col_t col, input bit sof);
    en_i = 1'b1; data_i = col; sof_i = sof;
    tick();
    en_i = 1'b0; sof_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_sigma(input int s);
    sigma_wr_i = 1'b1; sigma_i = D'(s);
    tick();
    sigma_wr_i = 1'b0;
  endtask

  task automatic sof_pulse();
    sof_i = 1'b1;
    tick();
    sof_i = 1'b0;
  endtask

  // Column c of a window: centre value, distance-1 ring value, everything else.
  function automatic col_t make_col(input int nb, input int d1, input int ctr, input int c);
    col_t col;
    int   v, ar, ac;
    col = '0;
    for (int r = 0; r < B; r++) begin
      ar = (r > C) ? r - C : C - r;
      ac = (c > C) ? c - C : C - c;
      if (ar == 0 && ac == 0)       v = ctr;
      else if (ar <= 1 && ac <= 1)  v = d1;
      else                          v = nb;
      col[(B-1-r)*D +: D] = D'(v);
    end
    return col;
  endfunction

  function automatic col_t rand_col(input int base);
    col_t col;
    int   v;
    col = '0;
    for (int r = 0; r < B; r++) begin
      case ($urandom_range(0, 11))
        0:       v = 0;
        1:       v = 4095;
        2:       v = $urandom_range(0, 4095);
        default: v = base + $urandom_range(0, 120) - 60;
      endcase
      col[(B-1-r)*D +: D] = D'(v);
    end
    return col;
  endfunction

  // ---------------------------------------------------------------------------
  // Table vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int    ctr;
    int    nb;
    int    d1;
    bit    mode;
    bit    byp;
    int    sig;
    int    exp_data;
    bit    exp_flag;
    string name;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    automatic int cur_sig = SIG0;
    automatic col_t a_col, s_col;

    tbl[0] = '{660,  500,  500,  1'b0, 1'b0, 160,  660,  1'b0, "thr c660"};
    tbl[1] = '{661,  500,  500,  1'b0, 1'b0, 160,  500,  1'b1, "thr c661"};
    tbl[2] = '{4095, 500,  500,  1'b0, 1'b0, 160,  500,  1'b1, "thr c4095"};
    tbl[3] = '{340,  500,  500,  1'b0, 1'b0, 160,  340,  1'b0, "thr c340"};
    tbl[4] = '{339,  500,  500,  1'b0, 1'b0, 160,  500,  1'b1, "thr c339"};
    tbl[5] = '{0,    500,  500,  1'b0, 1'b0, 160,  500,  1'b1, "thr c0"};
    tbl[6] = '{1000, 1000, 4095, 1'b1, 1'b0, 160,  1000, 1'b0, "mode bayer"};
    tbl[7] = '{1000, 1000, 4095, 1'b0, 1'b0, 160,  4095, 1'b1, "mode mono"};
    tbl[8] = '{4095, 500,  500,  1'b0, 1'b1, 160,  4095, 1'b0, "bypass"};
    tbl[9] = '{4095, 500,  500,  1'b0, 1'b0, 4000, 4095, 1'b0, "sigma4000"};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset data_o", data_o, 0);
    check("reset en_o", en_o, 0);
    check("reset flag_o", flag_o, 0);
    check("reset noise_cnt_o", noise_cnt_o, 0);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Fill and latency
    sof_pulse();
    for (int c = 0; c < B; c++) begin
      beat(make_col(500, 500, 500, c), 1'b0);
      check("fill no en_o", en_o, 0);
    end
    idle(1);
    check("latency t+1 en_o", en_o, 0);
    idle(1);
    check("latency t+2 en_o", en_o, 1);
    check("latency data_o", data_o, 500);
    check("latency flag_o", flag_o, 0);
    idle(1);

    // Table: thresholds, mode contrast, bypass, sigma write
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].sig != cur_sig) begin
        write_sigma(tbl[i].sig);
        cur_sig = tbl[i].sig;
      end
      mode_i   = tbl[i].mode;
      bypass_i = tbl[i].byp;
      for (int c = 0; c < B; c++)
        beat(make_col(tbl[i].nb, tbl[i].d1, tbl[i].ctr, c), 1'b0);
      idle(2);
      check({tbl[i].name, " en_o"}, en_o, 1);
      check({tbl[i].name, " data_o"}, data_o, tbl[i].exp_data);
      check({tbl[i].name, " flag_o"}, flag_o, tbl[i].exp_flag);
      idle(1);
    end

    // Spike among zeros with sigma 4000 still still noisy (no wrap)
    for (int c = 0; c < B; c++) beat(make_col(0, 0, 4095, c), 1'b0);
    idle(2);
    check("nowrap data_o", data_o, 0);
    check("nowrap flag_o", flag_o, 1);
    idle(2);

    // Counter: 3 noisy + 4 clean windows in one frame, then an all-clean frame
    write_sigma(SIG0);
    mode_i = 1'b0; bypass_i = 1'b0;
    a_col = make_col(500, 500, 500, 0);
    s_col = a_col;
    s_col[(B-1-C)*D +: D] = D'(4095);
    sof_pulse();
    beat(a_col, 1'b0); beat(a_col, 1'b0); beat(s_col, 1'b0); beat(a_col, 1'b0);
    beat(s_col, 1'b0); beat(a_col, 1'b0); beat(s_col, 1'b0);
    for (int i = 0; i < 4; i++) beat(a_col, 1'b0);
    idle(3);
    sof_pulse();
    check("frame count 3", noise_cnt_o, 3);
    for (int i = 0; i < B; i++) beat(a_col, 1'b0);
    idle(3);
    sof_pulse();
    check("frame count 0", noise_cnt_o, 0);

    // Gaps: en_i 1-0-1 reproduces as en_o 1-0-1 two clocks later
    for (int i = 0; i < B; i++) beat(a_col, 1'b0);
    idle(3);
    beat(a_col, 1'b0);
    idle(1);
    beat(a_col, 1'b0);
    check("gap t+2", en_o, 1);
    idle(1);
    check("gap t+3", en_o, 0);
    idle(1);
    check("gap t+4", en_o, 1);

    // Reset mid-stream with the pipeline full
    for (int i = 0; i < B; i++) beat(make_col(700, 4095, 0, i), 1'b0);
    en_i = 1'b1; data_i = a_col;
    rst_n  = 1'b0;
    mon_on = 1'b0;
    #1;
    check("midrst data_o", data_o, 0);
    check("midrst en_o", en_o, 0);
    check("midrst flag_o", flag_o, 0);
    check("midrst noise_cnt_o", noise_cnt_o, 0);
    en_i = 1'b0;
    hist.delete();
    exp_at.delete();
    m_fill = 0; m_sigma = SIG0; m_run = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_on = 1'b1;
    for (int i = 0; i < B - 1; i++) begin
      beat(a_col, 1'b0);
      check("post-rst no en_o", en_o, 0);
    end
    idle(3);
    check("post-rst idle en_o", en_o, 0);

    // Randomised bursts against the model
    for (int burst = 0; burst < 40; burst++) begin
      automatic int base = $urandom_range(300, 3700);
      mode_i   = $urandom_range(0, 1);
      bypass_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) write_sigma($urandom_range(20, 600));
      for (int n = 0; n < 24; n++) begin
        en_i   = ($urandom_range(0, 3) != 0);
        sof_i  = ($urandom_range(0, 29) == 0);
        data_i = rand_col(base);
        tick();
      end
      en_i = 1'b0; sof_i = 1'b0;
      idle(3);
    end
    sof_pulse();
    idle(2);

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sp_noise_removal_cfg.md
Name: sp_noise_removal_cfg

Overview:
- Next-generation salt-and-pepper noise remover for the RAW denoise chain. Parametrised in pixel depth and window size (3 or 5).
- Adds run-time mode control (mono or Bayer same-colour neighbourhood), a run-time threshold, bypass, a per-pixel replace flag and a per-frame noise counter.
- Consumes one vertical column of BWIDTH pixels per en_i beat from the upstream line buffer. Emits one corrected centre pixel per completed window.

Parameters:
- DATADEPTH, 12, pixel bit width.
- BWIDTH, 5, window size; legal values are 3 and 5 only.
- SIGMA, 160, reset value of the internal threshold register.
- CNTW, 20, width of the noise counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- en_i  input  1  column valid.
- data_i  input  DATADEPTH*BWIDTH  pixel column. Top row is in the MSB slice.
- sof_i  input  1  start-of-frame pulse, one cycle wide.
- mode_i  input  1  neighbourhood select: 0 = mono, 1 = Bayer.
- bypass_i  input  1  1 = pass the centre pixel through unmodified.
- sigma_wr_i  input  1  threshold write strobe.
- sigma_i  input  DATADEPTH  threshold write data.
- data_o  output  DATADEPTH  output pixel.
- en_o  output  1  output valid.
- flag_o  output  1  1 = this pixel was replaced; aligned with en_o.
- noise_cnt_o  output  CNTW  replaced-pixel count of the previous frame.

Behaviour:
- Reset values:
  - data_o = 0, en_o = 0, flag_o = 0, noise_cnt_o = 0.
  - Threshold register = SIGMA. Window contents = 0. Fill counter = 0. Running count = 0.
- Window:
  - BWIDTH column registers, shifted only when en_i = 1.
  - The newest column is the rightmost. The centre pixel is at (c,c), where c = BWIDTH/2.
- Fill counter:
  - Counts accepted columns and saturates at BWIDTH.
  - A window is valid on the en_i beat that brings the count to BWIDTH, and on every en_i beat after that.
  - sof_i resets the count to 0. If sof_i and en_i are high together, that column is counted as column 1 of the new frame.
- Neighbour sets (8 pixels each):
  - Mono mode: the 3x3 ring around the centre.
  - Bayer mode: the pixels at offset ±2 in row and/or column.
  - If BWIDTH = 3, mode_i is ignored and mono mode is used.
- Replacement value:
  - Mono: sum of the 4 orthogonal neighbours at distance 1, shifted right by 2.
  - Bayer: the same, using the orthogonal neighbours at distance 2.
- Pipeline: fixed, no stall.
  - S1 registers nb_min, nb_max, the 4-neighbour sum (DATADEPTH+2 bits), the centre, the threshold, mode, bypass and valid.
  - S2 registers data_o, flag_o and en_o.
  - en_o rises exactly 2 clocks after the en_i edge that completes a valid window.
  - Gaps in en_i reproduce as identical gaps in en_o.
- Detection is done at DATADEPTH+1 bits, so there is no wrap:
  - noisy if centre > nb_max + sigma, or centre + sigma < nb_min.
  - The comparisons are strict. Equality is not noisy.
- Output select:
  - If noisy and bypass = 0: data_o = replacement value, flag_o = 1.
  - Otherwise: data_o = centre, flag_o = 0.
- Threshold register:
  - Loaded from sigma_i on sigma_wr_i.
  - Sampled into S1 with each window, so a write affects only windows that reach S1 after the write.
- Counter:
  - The running count increments on every en_o with flag_o = 1, and saturates at all-ones.
  - On sof_i: noise_cnt_o <= running count, and the running count is cleared.
  - If a flagged pixel emerges in the same cycle as sof_i, it is counted in the new frame.
- Frame boundary: pixels still in S1/S2 when sof_i arrives drain normally.
- Asynchronous reset mid-stream clears all state immediately. en_o is 0 until a new window fills.

Test Plan:
- Fill and latency: rst release, sof_i, 5 columns of 500 with mode 0 and sigma 160. The 5th column is accepted at edge t. Required: en_o = 1 at edge t+2 with data_o = 500, flag_o = 0, and no en_o before that.
- Thresholds: all neighbours 500, mono mode; centres fed in turn.
  - Centre 660 -> data_o 660, flag_o 0.
  - Centre 661 -> data_o 500, flag_o 1.
  - Centre 4095 -> 500, flag 1.
  - Centre 340 -> 340, flag 0.
  - Centre 339 -> 500, flag 1.
  - Centre 0 -> 500, flag 1.
- Mode contrast: distance-2 ring = 1000, distance-1 pixels = 4095, centre = 1000.
  - mode_i = 1 -> data_o 1000, flag 0.
  - mode_i = 0 -> data_o 4095, flag 1.
- Bypass and sigma write:
  - Centre 4095 among 500s with bypass_i = 1 -> data_o 4095, flag 0.
  - With bypass_i = 0 and sigma written to 4000 -> data_o 4095, flag 0.
  - Centre 4095 among 0s with sigma 4000 -> data_o 0, flag 1 (no overflow wrap).
- Counter: sof_i, stream 3 noisy and 4 clean pixels, then sof_i -> noise_cnt_o = 3. A second frame with 0 noisy pixels -> noise_cnt_o = 0.
- Gaps and reset:
  - Toggle en_i 1-0-1 after fill -> en_o pattern 1-0-1, shifted by 2 cycles.
  - Assert rst_n low while the pipeline is full -> all outputs 0 immediately. After release, 4 columns give no en_o.
